// File: rtl/wb_stage.sv
// RV32I writeback: takes retired instructions, finishes loads, and pulses the register-file write port.
// Latency: non-load writes one cycle after accept; load writes one cycle after dmem_rvalid.
// Backpressure: in_ready drops while a load waits for memory, and rises again in the cycle the load writes back.
module wb_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rd,
    input  logic        in_rd_wen,
    input  logic [31:0] in_result,
    input  logic        in_is_load,
    input  logic [2:0]  in_funct3,
    input  logic [1:0]  in_addr_lo,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_wdata,
    output logic        rd_wen,
    output logic        load_misaligned,
    output logic [63:0] instret
);

    typedef enum logic [0:0] {IDLE, WAIT_LOAD} state_t;

    state_t      state_q, state_d;
    logic [4:0]  rd_addr_q, rd_addr_d;
    logic [31:0] rd_wdata_q, rd_wdata_d;
    logic        rd_wen_q, rd_wen_d;
    logic        load_misaligned_q, load_misaligned_d;
    logic [63:0] instret_q, instret_d;
    logic [4:0]  pend_rd_q, pend_rd_d;
    logic        pend_wen_q, pend_wen_d;
    logic [2:0]  pend_funct3_q, pend_funct3_d;
    logic [1:0]  pend_addr_q, pend_addr_d;

    logic        accept;
    logic        load_legal;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid && in_ready;

    // Illegal funct3 encodings are folded into the misaligned check.
    always_comb begin
        load_legal = 1'b0;
        case (in_funct3)
            3'b000, 3'b100: load_legal = 1'b1;
            3'b001, 3'b101: load_legal = ~in_addr_lo[0];
            3'b010:         load_legal = (in_addr_lo == 2'b00);
            default:        load_legal = 1'b0;
        endcase
    end

    always_comb begin
        byte_sel = dmem_rdata[7:0];
        case (pend_addr_q)
            2'd0:    byte_sel = dmem_rdata[7:0];
            2'd1:    byte_sel = dmem_rdata[15:8];
            2'd2:    byte_sel = dmem_rdata[23:16];
            default: byte_sel = dmem_rdata[31:24];
        endcase
        half_sel  = pend_addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        load_data = dmem_rdata;
        case (pend_funct3_q)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_data = {24'd0, byte_sel};
            3'b101:  load_data = {16'd0, half_sel};
            default: load_data = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d           = state_q;
        rd_addr_d         = rd_addr_q;
        rd_wdata_d        = rd_wdata_q;
        rd_wen_d          = 1'b0;
        load_misaligned_d = 1'b0;
        instret_d         = instret_q;
        pend_rd_d         = pend_rd_q;
        pend_wen_d        = pend_wen_q;
        pend_funct3_d     = pend_funct3_q;
        pend_addr_d       = pend_addr_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!in_is_load) begin
                        rd_wen_d  = in_rd_wen && (in_rd != 5'd0);
                        instret_d = instret_q + 64'd1;
                        // Address/data only move on a real write so they hold otherwise.
                        if (in_rd_wen && (in_rd != 5'd0)) begin
                            rd_addr_d  = in_rd;
                            rd_wdata_d = in_result;
                        end
                    end else if (load_legal) begin
                        pend_rd_d     = in_rd;
                        pend_wen_d    = in_rd_wen;
                        pend_funct3_d = in_funct3;
                        pend_addr_d   = in_addr_lo;
                        state_d       = WAIT_LOAD;
                    end else begin
                        load_misaligned_d = 1'b1;
                    end
                end
            end
            WAIT_LOAD: begin
                if (dmem_rvalid) begin
                    rd_wen_d  = pend_wen_q && (pend_rd_q != 5'd0);
                    instret_d = instret_q + 64'd1;
                    if (pend_wen_q && (pend_rd_q != 5'd0)) begin
                        rd_addr_d  = pend_rd_q;
                        rd_wdata_d = load_data;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= IDLE;
            rd_addr_q         <= 5'd0;
            rd_wdata_q        <= 32'd0;
            rd_wen_q          <= 1'b0;
            load_misaligned_q <= 1'b0;
            instret_q         <= 64'd0;
            pend_rd_q         <= 5'd0;
            pend_wen_q        <= 1'b0;
            pend_funct3_q     <= 3'd0;
            pend_addr_q       <= 2'd0;
        end else begin
            state_q           <= state_d;
            rd_addr_q         <= rd_addr_d;
            rd_wdata_q        <= rd_wdata_d;
            rd_wen_q          <= rd_wen_d;
            load_misaligned_q <= load_misaligned_d;
            instret_q         <= instret_d;
            pend_rd_q         <= pend_rd_d;
            pend_wen_q        <= pend_wen_d;
            pend_funct3_q     <= pend_funct3_d;
            pend_addr_q       <= pend_addr_d;
        end
    end

    assign rd_addr         = rd_addr_q;
    assign rd_wdata        = rd_wdata_q;
    assign rd_wen          = rd_wen_q;
    assign load_misaligned = load_misaligned_q;
    assign instret         = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: each task drives one scenario and checks outputs 1 time unit after the edge.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_rd_wen;
    logic [31:0] in_result;
    logic        in_is_load;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic        rd_wen;
    logic        load_misaligned;
    logic [63:0] instret;

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] exp_instret = 64'd0;

    wb_stage dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_rd          (in_rd),
        .in_rd_wen      (in_rd_wen),
        .in_result      (in_result),
        .in_is_load     (in_is_load),
        .in_funct3      (in_funct3),
        .in_addr_lo     (in_addr_lo),
        .dmem_rvalid    (dmem_rvalid),
        .dmem_rdata     (dmem_rdata),
        .rd_addr        (rd_addr),
        .rd_wdata       (rd_wdata),
        .rd_wen         (rd_wen),
        .load_misaligned(load_misaligned),
        .instret        (instret)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [4:0] rd, input logic wen, input logic [31:0] res,
                            input logic ld, input logic [2:0] f3, input logic [1:0] alo);
        in_valid   = 1'b1;
        in_rd      = rd;
        in_rd_wen  = wen;
        in_result  = res;
        in_is_load = ld;
        in_funct3  = f3;
        in_addr_lo = alo;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_rd = '0; in_rd_wen = 1'b0; in_result = '0;
        in_is_load = 1'b0; in_funct3 = '0; in_addr_lo = '0;
        dmem_rvalid = 1'b0; dmem_rdata = '0;
        tick();
        tick();
        n_vec++; if (rd_wen !== 1'b0) begin n_err++; $display("FAIL reset_rd_wen got %b exp 0", rd_wen); end
        n_vec++; if (rd_addr !== 5'd0) begin n_err++; $display("FAIL reset_rd_addr got %0d exp 0", rd_addr); end
        n_vec++; if (rd_wdata !== 32'd0) begin n_err++; $display("FAIL reset_rd_wdata got %h exp 0", rd_wdata); end
        n_vec++; if (load_misaligned !== 1'b0) begin n_err++; $display("FAIL reset_misaligned got %b exp 0", load_misaligned); end
        n_vec++; if (instret !== 64'd0) begin n_err++; $display("FAIL reset_instret got %0d exp 0", instret); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_nonload();
        drive_op(5'd5, 1'b1, 32'h1234_5678, 1'b0, 3'd0, 2'd0);
        tick();
        in_valid = 1'b0;
        exp_instret = exp_instret + 64'd1;
        n_vec++; if (rd_wen !== 1'b1) begin n_err++; $display("FAIL alu_rd_wen got %b exp 1", rd_wen); end
        n_vec++; if (rd_addr !== 5'd5) begin n_err++; $display("FAIL alu_rd_addr got %0d exp 5", rd_addr); end
        n_vec++; if (rd_wdata !== 32'h1234_5678) begin n_err++; $display("FAIL alu_rd_wdata got %h exp 12345678", rd_wdata); end
        n_vec++; if (instret !== exp_instret) begin n_err++; $display("FAIL alu_instret got %0d exp %0d", instret, exp_instret); end
        tick();
        n_vec++; if (rd_wen !== 1'b0) begin n_err++; $display("FAIL alu_pulse_end got %b exp 0", rd_wen); end
        n_vec++; if (rd_addr !== 5'd5 || rd_wdata !== 32'h1234_5678) begin
            n_err++; $display("FAIL alu_hold got %0d/%h exp 5/12345678", rd_addr, rd_wdata); end
    endtask

    task automatic test_x0_and_back_to_back();
        drive_op(5'd0, 1'b1, 32'hCAFE_F00D, 1'b0, 3'd0, 2'd0);
        tick();
        in_valid = 1'b0;
        exp_instret = exp_instret + 64'd1;
        n_vec++; if (rd_wen !== 1'b0) begin n_err++; $display("FAIL x0_rd_wen got %b exp 0", rd_wen); end
        n_vec++; if (instret !== exp_instret) begin n_err++; $display("FAIL x0_instret got %0d exp %0d", instret, exp_instret); end
        for (int i = 1; i <= 4; i++) begin
            drive_op(5'(i), 1'b1, 32'h0000_1000 + 32'(i), 1'b0, 3'd0, 2'd0);
            tick();
            exp_instret = exp_instret + 64'd1;
            n_vec++; if (rd_wen !== 1'b1 || rd_addr !== 5'(i) || rd_wdata !== 32'h0000_1000 + 32'(i)) begin
                n_err++; $display("FAIL b2b_%0d got wen=%b rd=%0d data=%h exp wen=1 rd=%0d data=%h",
                                  i, rd_wen, rd_addr, rd_wdata, i, 32'h0000_1000 + 32'(i)); end
            n_vec++; if (instret !== exp_instret) begin n_err++; $display("FAIL b2b_instret_%0d got %0d exp %0d", i, instret, exp_instret); end
        end
        in_valid = 1'b0;
        tick();
        n_vec++; if (rd_wen !== 1'b0) begin n_err++; $display("FAIL b2b_end got %b exp 0", rd_wen); end
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [1:0]  alo [5] = '{2'd0, 2'd3, 2'd2, 2'd0, 2'd0};
        logic [31:0] exp [5] = '{32'hFFFF_FF81, 32'h0000_0080, 32'hFFFF_80F0, 32'h0000_7F81, 32'h80F0_7F81};
        for (int k = 0; k < 5; k++) begin
            drive_op(5'(10 + k), 1'b1, 32'h5555_5555, 1'b1, f3[k], alo[k]);
            dmem_rvalid = 1'b0;
            tick();
            in_valid = 1'b0;
            n_vec++; if (in_ready !== 1'b0 || rd_wen !== 1'b0) begin
                n_err++; $display("FAIL ld%0d_wait got ready=%b wen=%b exp 0/0", k, in_ready, rd_wen); end
            dmem_rvalid = 1'b1;
            dmem_rdata  = 32'h80F0_7F81;
            tick();
            dmem_rvalid = 1'b0;
            exp_instret = exp_instret + 64'd1;
            n_vec++; if (rd_wen !== 1'b1 || rd_addr !== 5'(10 + k) || rd_wdata !== exp[k]) begin
                n_err++; $display("FAIL ld%0d_data got wen=%b rd=%0d data=%h exp wen=1 rd=%0d data=%h",
                                  k, rd_wen, rd_addr, rd_wdata, 10 + k, exp[k]); end
            n_vec++; if (in_ready !== 1'b1 || instret !== exp_instret) begin
                n_err++; $display("FAIL ld%0d_done got ready=%b instret=%0d exp 1/%0d", k, in_ready, instret, exp_instret); end
        end
    endtask

    task automatic test_load_stall();
        drive_op(5'd7, 1'b1, 32'h0, 1'b1, 3'b010, 2'd0);
        tick();
        drive_op(5'd8, 1'b1, 32'h0000_AAAA, 1'b0, 3'd0, 2'd0);
        for (int c = 0; c < 5; c++) begin
            n_vec++; if (in_ready !== 1'b0 || rd_wen !== 1'b0) begin
                n_err++; $display("FAIL stall_%0d got ready=%b wen=%b exp 0/0", c, in_ready, rd_wen); end
            tick();
        end
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hDEAD_BEEF;
        tick();
        dmem_rvalid = 1'b0;
        exp_instret = exp_instret + 64'd1;
        n_vec++; if (rd_wen !== 1'b1 || rd_addr !== 5'd7 || rd_wdata !== 32'hDEAD_BEEF || in_ready !== 1'b1) begin
            n_err++; $display("FAIL stall_load got wen=%b rd=%0d data=%h ready=%b exp 1/7/deadbeef/1",
                              rd_wen, rd_addr, rd_wdata, in_ready); end
        tick();
        in_valid = 1'b0;
        exp_instret = exp_instret + 64'd1;
        n_vec++; if (rd_wen !== 1'b1 || rd_addr !== 5'd8 || rd_wdata !== 32'h0000_AAAA) begin
            n_err++; $display("FAIL stall_next got wen=%b rd=%0d data=%h exp 1/8/0000aaaa", rd_wen, rd_addr, rd_wdata); end
        n_vec++; if (instret !== exp_instret) begin n_err++; $display("FAIL stall_instret got %0d exp %0d", instret, exp_instret); end
    endtask

    task automatic test_misaligned();
        drive_op(5'd3, 1'b1, 32'h0, 1'b1, 3'b010, 2'd2);
        tick();
        in_valid = 1'b0;
        n_vec++; if (load_misaligned !== 1'b1 || rd_wen !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL mis_lw got mis=%b wen=%b ready=%b exp 1/0/1", load_misaligned, rd_wen, in_ready); end
        n_vec++; if (instret !== exp_instret) begin n_err++; $display("FAIL mis_instret got %0d exp %0d", instret, exp_instret); end
        tick();
        n_vec++; if (load_misaligned !== 1'b0) begin n_err++; $display("FAIL mis_pulse_end got %b exp 0", load_misaligned); end
        drive_op(5'd3, 1'b1, 32'h0, 1'b1, 3'b011, 2'd0);
        tick();
        in_valid = 1'b0;
        n_vec++; if (load_misaligned !== 1'b1 || rd_wen !== 1'b0) begin
            n_err++; $display("FAIL mis_f3 got mis=%b wen=%b exp 1/0", load_misaligned, rd_wen); end
        drive_op(5'd3, 1'b1, 32'h0, 1'b1, 3'b001, 2'd1);
        tick();
        in_valid = 1'b0;
        n_vec++; if (load_misaligned !== 1'b1 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL mis_lh got mis=%b ready=%b exp 1/1", load_misaligned, in_ready); end
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1111_2222;
        tick();
        dmem_rvalid = 1'b0;
        n_vec++; if (rd_wen !== 1'b0 || instret !== exp_instret || load_misaligned !== 1'b0) begin
            n_err++; $display("FAIL stray_rvalid got wen=%b instret=%0d mis=%b exp 0/%0d/0",
                              rd_wen, instret, load_misaligned, exp_instret); end
    endtask

    task automatic test_async_reset();
        drive_op(5'd9, 1'b1, 32'h0, 1'b1, 3'b010, 2'd0);
        tick();
        in_valid = 1'b0;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL arst_pre got ready=%b exp 0", in_ready); end
        #2;
        rst = 1'b1;
        #1;
        exp_instret = 64'd0;
        n_vec++; if (in_ready !== 1'b1 || rd_wen !== 1'b0 || rd_addr !== 5'd0 || rd_wdata !== 32'd0) begin
            n_err++; $display("FAIL arst_now got ready=%b wen=%b rd=%0d data=%h exp 1/0/0/0",
                              in_ready, rd_wen, rd_addr, rd_wdata); end
        n_vec++; if (instret !== 64'd0) begin n_err++; $display("FAIL arst_instret got %0d exp 0", instret); end
        rst = 1'b0;
        tick();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h7777_7777;
        tick();
        dmem_rvalid = 1'b0;
        n_vec++; if (rd_wen !== 1'b0 || instret !== exp_instret || rd_wdata !== 32'd0) begin
            n_err++; $display("FAIL arst_late_rvalid got wen=%b instret=%0d data=%h exp 0/0/0",
                              rd_wen, instret, rd_wdata); end
    endtask

    initial begin
        test_reset();
        test_nonload();
        test_x0_and_back_to_back();
        test_load_ext();
        test_load_stall();
        test_misaligned();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the RV32I pipeline. It accepts completed instructions from the memory stage over a valid/ready handshake. For loads, it waits for the data-memory response, then extracts and sign- or zero-extends the requested byte, halfword or word. It drives the register file write port (`rd_addr`, `rd_wdata`, `rd_wen`) with a registered, one-cycle write pulse and keeps the retired-instruction counter.

## Interface
- No parameters; data width is fixed at 32, register index at 5.
- Clocking and reset: one clock; reset is asynchronous and active-high.
- `clk` input 1: pipeline clock.
- `rst` input 1: asynchronous active-high reset.
- `in_valid` input 1: memory stage presents an instruction.
- `in_ready` output 1: stage can accept; equals (state == IDLE).
- `in_rd` input 5: destination register index.
- `in_rd_wen` input 1: instruction writes a destination register.
- `in_result` input 32: ALU/JAL/LUI result; ignored for loads.
- `in_is_load` input 1: instruction is a load.
- `in_funct3` input 3: load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- `in_addr_lo` input 2: load effective address bits [1:0].
- `dmem_rvalid` input 1: load data valid, single-cycle pulse.
- `dmem_rdata` input 32: aligned word from data memory.
- `rd_addr` output 5: register file write index.
- `rd_wdata` output 32: register file write data.
- `rd_wen` output 1: register file write enable, one-cycle pulse.
- `load_misaligned` output 1: one-cycle pulse on misaligned or illegal-funct3 load.
- `instret` output 64: retired instruction count.

## Operation
- Acceptance occurs on a clock edge where `in_valid && in_ready`.
- States: IDLE, WAIT_LOAD.
- IDLE, accept non-load:
  - Next cycle: `rd_addr`=`in_rd`, `rd_wdata`=`in_result`, `rd_wen`=`in_rd_wen && in_rd != 0`.
  - `instret` increments. State stays IDLE.
- IDLE, accept load with legal alignment:
  - Alignment is legal when: LB/LBU any address; LH/LHU `addr_lo[0]==0`; LW `addr_lo==0`.
  - Latch rd, rd_wen, funct3 and addr_lo; go to WAIT_LOAD. No write this cycle.
- IDLE, accept load that is misaligned, or has funct3 011/110/111:
  - Next cycle: `load_misaligned`=1, `rd_wen`=0, `instret` unchanged. State stays IDLE.
- WAIT_LOAD: `in_ready`=0. On `dmem_rvalid`:
  - Byte loads select `dmem_rdata[8*addr_lo +: 8]`.
  - Halfword loads select `dmem_rdata[16*addr_lo[1] +: 16]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Next cycle: write pulse with the latched rd and `rd_wen` = latched wen && rd != 0; `instret` increments; state returns to IDLE.
- `dmem_rvalid` in IDLE is ignored; no write, no counter change.
- A retired instruction with rd==0 or `in_rd_wen`=0 still increments `instret` but produces `rd_wen`=0.
- `instret` wraps from 2^64-1 to 0.
- `rd_addr` and `rd_wdata` hold their last value when `rd_wen`=0.

## Timing
- All outputs except `in_ready` are registered. `in_ready` is a combinational decode of state.
- Reset values: state IDLE, `rd_wen`=0, `rd_addr`=0, `rd_wdata`=0, `load_misaligned`=0, `instret`=0. `in_ready`=1 after reset.
- Non-load latency: accept at edge N, `rd_wen` high during cycle N+1 (1 cycle).
- Back-to-back non-loads: one write per cycle, no bubbles.
- Load latency: `dmem_rvalid` sampled at edge M, write during cycle M+1.
- `in_ready` rises in cycle M+1, so the next accept is at edge M+1 at the earliest.
- `dmem_rvalid` in the same cycle as load acceptance belongs to no outstanding load and is ignored. Memory must respond no earlier than the cycle after acceptance.
- Reset asserted in WAIT_LOAD: the pending load is discarded and state goes to IDLE asynchronously. A later `dmem_rvalid` is ignored.

## Test plan
- Reset then non-load: accept rd=5, result=0x1234_5678, wen=1 → next cycle `rd_wen`=1, `rd_addr`=5, `rd_wdata`=0x1234_5678, `instret`=1.
- Write to x0: accept rd=0, wen=1 → `rd_wen`=0 and `instret` increments. Also run 4 back-to-back ALU ops → 4 consecutive write pulses.
- Load extension with `dmem_rdata`=0x80F0_7F81:
  - LB addr_lo=0 → 0xFFFF_FF81; LBU addr_lo=3 → 0x0000_0080.
  - LH addr_lo=2 → 0xFFFF_80F0; LHU addr_lo=0 → 0x0000_7F81.
  - LW → 0x80F0_7F81.
- Load stall: accept LW, hold `dmem_rvalid` low 5 cycles with `in_valid` high → `in_ready`=0 for 5 cycles. Then rvalid → write next cycle, following instruction accepted one cycle after.
- Misaligned LW addr_lo=2 → `load_misaligned` pulse, no write, `instret` unchanged. A stray `dmem_rvalid` in IDLE → no effect.
- Async reset asserted mid-WAIT_LOAD → outputs 0, `in_ready`=1 immediately. Later `dmem_rvalid` → no write.
